vga_pixel_unpack: RTL

Downstream consumer of the line-buffer FIFO in the VGA/LCD controller. Pulls 32-bit words from the FIFO read port, keeps a small byte queue, and on each pixel request from the timing generator emits one 24-bit RGB pixel unpacked for the programmed colour depth. Reports underruns when the FIFO cannot keep up with the display.

---
 rtl/vga_pixel_unpack.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/vga_pixel_unpack.sv
// rtl/vga_pixel_unpack.sv - line-buffer word to RGB pixel unpacker with a 12-byte queue
// Optional 24bpp packed mode enabled by defining VGA_PIXEL_24BPP_EN.
module vga_pixel_unpack (
    input  logic        clk,
    input  logic        aclr,
    input  logic        sclr,
    input  logic [1:0]  cdepth,
    input  logic [31:0] fifo_q,
    input  logic        fifo_empty,
    output logic        fifo_rreq,
    input  logic        pix_req,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        pix_valid,
    output logic        underrun
);

    // Byte i of the queue lives at bits [8*i +: 8]; byte 0 is the head.
    logic [95:0] queue_q, queue_d;
    logic [3:0]  bcnt_q, bcnt_d;
    logic [1:0]  infl_q, infl_d;
    logic        land_q, land_d;
    logic [1:0]  cdepth_q, cdepth_d;
    logic [7:0]  r_q, r_d;
    logic [7:0]  g_q, g_d;
    logic [7:0]  b_q, b_d;
    logic        pix_valid_q, pix_valid_d;
    logic        underrun_q, underrun_d;

    logic [3:0]  bpp;
    logic        have_pixel;
    logic        serve;
    logic [3:0]  pop;
    logic [3:0]  base;
    logic [7:0]  px_r, px_g, px_b;
    logic [15:0] w565;
    logic [7:0]  qb0, qb1, qb2, qb3;
    logic [7:0]  wb [4];
    logic [4:0]  room_sum;

    assign qb0 = queue_q[7:0];
    assign qb1 = queue_q[15:8];
    assign qb2 = queue_q[23:16];
    assign qb3 = queue_q[31:24];

    assign wb[0] = fifo_q[31:24];
    assign wb[1] = fifo_q[23:16];
    assign wb[2] = fifo_q[15:8];
    assign wb[3] = fifo_q[7:0];

    // Fetch only while the queue can absorb every word already requested.
    assign room_sum  = {1'b0, bcnt_q} + {1'b0, infl_q, 2'b00};
    assign fifo_rreq = !sclr && !fifo_empty && (room_sum <= 5'd8);

    always_comb begin
        bpp = 4'd4;
        case (cdepth_q)
            2'b00:   bpp = 4'd1;
            2'b01:   bpp = 4'd2;
`ifdef VGA_PIXEL_24BPP_EN
            2'b10:   bpp = 4'd3;
`endif
            default: bpp = 4'd4;
        endcase
    end

    assign have_pixel = (bcnt_q >= bpp);
    assign serve      = pix_req && have_pixel && !sclr;
    assign pop        = serve ? bpp : 4'd0;
    assign base       = bcnt_q - pop;
    assign w565       = {qb0, qb1};

    always_comb begin
        px_r = qb1;
        px_g = qb2;
        px_b = qb3;
        case (cdepth_q)
            2'b00: begin
                px_r = qb0;
                px_g = qb0;
                px_b = qb0;
            end
            2'b01: begin
                px_r = {w565[15:11], w565[15:13]};
                px_g = {w565[10:5],  w565[10:9]};
                px_b = {w565[4:0],   w565[4:2]};
            end
`ifdef VGA_PIXEL_24BPP_EN
            2'b10: begin
                px_r = qb0;
                px_g = qb1;
                px_b = qb2;
            end
`endif
            default: begin
                px_r = qb1;
                px_g = qb2;
                px_b = qb3;
            end
        endcase
    end

    // Pop from the head, then drop a landing word in right behind the survivors.
    always_comb begin
        int idx;
        idx     = 0;
        queue_d = queue_q >> {pop, 3'b000};
        bcnt_d  = bcnt_q - pop + (land_q ? 4'd4 : 4'd0);
        if (land_q) begin
            for (int i = 0; i < 12; i++) begin
                idx = i - int'(base);
                if (idx >= 0 && idx < 4) begin
                    queue_d[8*i +: 8] = wb[idx[1:0]];
                end
            end
        end
        if (sclr) begin
            queue_d = '0;
            bcnt_d  = 4'd0;
        end
    end

    always_comb begin
        infl_d = infl_q;
        case ({fifo_rreq, land_q})
            2'b10:   infl_d = infl_q + 2'd1;
            2'b01:   infl_d = infl_q - 2'd1;
            default: infl_d = infl_q;
        endcase
    end

    assign land_d   = fifo_rreq;
    assign cdepth_d = sclr ? cdepth : cdepth_q;

    always_comb begin
        r_d         = r_q;
        g_d         = g_q;
        b_d         = b_q;
        pix_valid_d = 1'b0;
        underrun_d  = 1'b0;
        if (sclr) begin
            r_d = 8'd0;
            g_d = 8'd0;
            b_d = 8'd0;
        end else if (pix_req) begin
            if (have_pixel) begin
                r_d         = px_r;
                g_d         = px_g;
                b_d         = px_b;
                pix_valid_d = 1'b1;
            end else begin
                r_d        = 8'd0;
                g_d        = 8'd0;
                b_d        = 8'd0;
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            queue_q     <= '0;
            bcnt_q      <= 4'd0;
            infl_q      <= 2'd0;
            land_q      <= 1'b0;
            cdepth_q    <= 2'b00;
            r_q         <= 8'd0;
            g_q         <= 8'd0;
            b_q         <= 8'd0;
            pix_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            queue_q     <= queue_d;
            bcnt_q      <= bcnt_d;
            infl_q      <= infl_d;
            land_q      <= land_d;
            cdepth_q    <= cdepth_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            pix_valid_q <= pix_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign r         = r_q;
    assign g         = g_q;
    assign b         = b_q;
    assign pix_valid = pix_valid_q;
    assign underrun  = underrun_q;

endmodule
